// File: rtl/block_allocator.sv
// Next-fit block allocator for the card-list RAM: scans fixed-size blocks for a clear tag bit,
// claims it, and supports explicit free. Owns the RAM port only while o_busy is high.
module block_allocator #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 32,
  parameter int FIRST_BLOCK = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_alloc_req,
  input  logic                  i_free_req,
  input  logic [ADDR_WIDTH-1:0] i_free_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_success,
  output logic [ADDR_WIDTH-1:0] o_out_address,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_wren,
  input  logic [DATA_WIDTH-1:0] i_ram_q
);
  localparam int NUM_BLOCKS = (2**ADDR_WIDTH) / BLOCK_WORDS;
  localparam int PW = $clog2(NUM_BLOCKS) + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(FIRST_BLOCK * BLOCK_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BSTEP = ADDR_WIDTH'(BLOCK_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BMASK = ADDR_WIDTH'(BLOCK_WORDS - 1);
  localparam logic [PW-1:0]         MAXP  = PW'(NUM_BLOCKS - FIRST_BLOCK);
  localparam logic [DATA_WIDTH-1:0] TAG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FREE, S_READ, S_WAIT, S_CHECK, S_WRITE, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_cur, w_cur_d, r_next_ptr, w_inc, w_succ;
  logic [PW-1:0]         r_probes, w_probes_d, w_probes_inc;
  logic                  r_free_ok, w_free_ok;
  logic                  r_done, r_success, r_ram_wren;
  logic [ADDR_WIDTH-1:0] r_out_address, r_ram_address;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic                  w_unused_q;

  assign w_unused_q   = ^i_ram_q[DATA_WIDTH-2:0];
  assign w_inc        = r_cur + BSTEP;
  // Stepping past the top block overflows to 0; restart at the first allocatable block.
  assign w_succ       = (w_inc == '0) ? BASE : w_inc;
  assign w_probes_inc = r_probes + PW'(1);
  assign w_free_ok    = ((i_free_addr & BMASK) == '0) && (i_free_addr >= BASE);

  always_comb begin
    w_next     = r_state;
    w_cur_d    = r_cur;
    w_probes_d = r_probes;
    case (r_state)
      S_IDLE: begin
        if (i_alloc_req) begin
          w_next     = S_READ;
          w_cur_d    = r_next_ptr;
          w_probes_d = '0;
        end else if (i_free_req) begin
          w_next = S_FREE;
        end
      end
      S_FREE:  w_next = S_DONE;
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = S_CHECK;
      S_CHECK: begin
        if (!i_ram_q[DATA_WIDTH-1]) begin
          w_next = S_WRITE;
        end else begin
          w_probes_d = w_probes_inc;
          if (w_probes_inc == MAXP) begin
            w_next = S_DONE;
          end else begin
            w_next  = S_READ;
            w_cur_d = w_succ;
          end
        end
      end
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cur         <= '0;
      r_probes      <= '0;
      r_next_ptr    <= BASE;
      r_free_ok     <= 1'b0;
      r_done        <= 1'b0;
      r_success     <= 1'b0;
      r_out_address <= '0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cur    <= w_cur_d;
      r_probes <= w_probes_d;
      if (r_state == S_IDLE) r_free_ok <= w_free_ok;
      r_done <= (w_next == S_DONE);
      if (w_next == S_DONE)
        r_success <= (r_state == S_WRITE) || ((r_state == S_FREE) && r_free_ok);
      // RAM controls are registered off the next state so they line up with the state they serve.
      r_ram_wren <= (w_next == S_WRITE) || ((w_next == S_FREE) && w_free_ok);
      r_ram_data <= (w_next == S_WRITE) ? TAG : '0;
      case (w_next)
        S_READ:  r_ram_address <= w_cur_d;
        S_FREE:  if (w_free_ok) r_ram_address <= i_free_addr;
        S_WRITE: r_ram_address <= r_cur;
        default: ;
      endcase
      if (r_state == S_WRITE) begin
        r_out_address <= r_cur;
        r_next_ptr    <= w_succ;
      end
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_success     = r_success;
  assign o_out_address = r_out_address;
  assign o_ram_address = r_ram_address;
  assign o_ram_data    = r_ram_data;
  assign o_ram_wren    = r_ram_wren;
endmodule

// File: tb/tb_block_allocator.sv
// Directed bench for block_allocator: behavioural RAM with two-edge read latency and a
// scoreboard of expected completions checked when done pulses.
module tb_block_allocator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_req = 1'b0, free_req = 1'b0;
  logic [9:0]  free_addr = '0;
  logic        busy, done, success, ram_wren;
  logic [9:0]  out_address, ram_address;
  logic [31:0] ram_data, ram_q, ram_p;
  logic [31:0] mem [0:1023];
  int          wr_cnt = 0;
  int          checks = 0, errors = 0;

  typedef struct {logic succ; logic [9:0] addr; int lat; int wr;} exp_t;
  exp_t sb[$];

  block_allocator dut (
    .i_clock(clk), .i_reset(rst), .i_alloc_req(alloc_req), .i_free_req(free_req),
    .i_free_addr(free_addr), .o_busy(busy), .o_done(done), .o_success(success),
    .o_out_address(out_address), .o_ram_address(ram_address), .o_ram_data(ram_data),
    .o_ram_wren(ram_wren), .i_ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_p <= mem[ram_address];
    ram_q <= ram_p;
    if (ram_wren) begin
      mem[ram_address] <= ram_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input bit a, input bit f, input logic [9:0] fa,
                    input logic es, input logic [9:0] ea, input int el, input int ew);
    exp_t e;
    int n, w0;
    e = '{es, ea, el, ew};
    sb.push_back(e);
    w0 = wr_cnt;
    alloc_req = a; free_req = f; free_addr = fa;
    @(posedge clk); #1;
    alloc_req = 0; free_req = 0;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, n, e.lat);
    chk({tag, "_succ"}, {31'b0, success}, {31'b0, e.succ});
    chk({tag, "_addr"}, {22'b0, out_address}, {22'b0, e.addr});
    chk({tag, "_wr"}, wr_cnt - w0, e.wr);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {30'b0, done, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {busy, done, success, ram_wren, out_address, ram_address}, '0);
    chk("rst_data", ram_data, '0);
    rst = 0;
    @(posedge clk); #1;

    op("alloc1", 1, 0, 0, 1, 10'd32, 4, 1);
    chk("mem32", mem[32], 32'h8000_0000);
    op("alloc2", 1, 0, 0, 1, 10'd64, 4, 1);
    op("free64", 0, 1, 10'd64, 1, 10'd64, 1, 1);
    chk("mem64", mem[64], 32'h0);
    op("alloc3", 1, 0, 0, 1, 10'd96, 4, 1);
    op("free65", 0, 1, 10'd65, 0, 10'd96, 1, 0);
    op("free0", 0, 1, 10'd0, 0, 10'd96, 1, 0);
    op("both", 1, 1, 10'd32, 1, 10'd128, 4, 1);
    chk("mem32_kept", mem[32], 32'h8000_0000);

    for (int k = 0; k < 26; k++) op("fill", 1, 0, 0, 1, 10'(160 + 32 * k), 4, 1);
    mem[992] = 32'h8000_0000;
    mem[32]  = 32'h0;
    op("wrap", 1, 0, 0, 1, 10'd32, 7, 1);

    mem[64] = 32'h8000_0000;
    op("full", 1, 0, 0, 0, 10'd32, 93, 0);
    mem[64] = 32'h0;
    mem[96] = 32'h0;
    op("after_full", 1, 0, 0, 1, 10'd64, 4, 1);

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    alloc_req = 1;
    @(posedge clk); #1;
    alloc_req = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("abort", {29'b0, busy, ram_wren, done}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("abort_idle", {30'b0, busy, done}, 32'd0);
    op("post_rst", 1, 0, 0, 1, 10'd32, 4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
